// File: rtl/apb_resp_mux_if.sv
// rtl/apb_resp_mux_if.sv - master-facing and slave-facing APB response signals of apb_resp_mux
interface apb_resp_mux_if #(
  parameter int NUM_SLAVES = 3,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = $clog2(NUM_SLAVES)
);
  logic                             m_psel;
  logic                             m_penable;
  logic [NUM_SLAVES-1:0]            sel;
  logic [NUM_SLAVES-1:0]            s_ready;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data;
  logic [NUM_SLAVES-1:0]            s_error;
  logic [DATA_WIDTH-1:0]            o_arbiter_DATA;
  logic                             o_arbiter_READY;
  logic                             o_arbiter_ERROR;
  logic [IDX_WIDTH-1:0]             o_arbiter_SEL;
  logic                             o_busy;

  modport slave (
    input  m_psel, m_penable, sel, s_ready, s_data, s_error,
    output o_arbiter_DATA, o_arbiter_READY, o_arbiter_ERROR, o_arbiter_SEL, o_busy
  );

  modport master (
    output m_psel, m_penable, sel, s_ready, s_data, s_error,
    input  o_arbiter_DATA, o_arbiter_READY, o_arbiter_ERROR, o_arbiter_SEL, o_busy
  );
endinterface

// File: rtl/apb_resp_mux.sv
// rtl/apb_resp_mux.sv - N-slave APB response mux with decode-error and timeout responses
// Optional error/timeout counters: define APB_RESP_MUX_STATS_EN.
module apb_resp_mux #(
  parameter int NUM_SLAVES     = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int IDX_WIDTH      = $clog2(NUM_SLAVES)
) (
  input  logic          PCLK,
  input  logic          PRESETn,
`ifdef APB_RESP_MUX_STATS_EN
  output logic [15:0]   o_err_cnt,
  output logic [15:0]   o_timeout_cnt,
`endif
  apb_resp_mux_if.slave bus
);
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state;
  logic [IDX_WIDTH-1:0]  idx;
  logic [IDX_WIDTH-1:0]  sel_idx;
  logic                  decode_err;
  logic                  sel_bad;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  in_access;
  logic                  slv_ready;
  logic                  slv_error;
  logic [DATA_WIDTH-1:0] slv_data;
  logic                  timeout;
  logic                  rsp_ready;
  logic                  rsp_error;

  // Lowest set bit wins; a malformed select is flagged by sel_bad anyway.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (bus.sel[i]) sel_idx = IDX_WIDTH'(i);
    end
  end

  assign sel_bad = (bus.sel == '0) || ((bus.sel & (bus.sel - NUM_SLAVES'(1))) != '0);

  always_comb begin
    slv_ready = 1'b0;
    slv_error = 1'b0;
    slv_data  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == IDX_WIDTH'(i)) begin
        slv_ready = bus.s_ready[i];
        slv_error = bus.s_error[i];
        slv_data  = bus.s_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A slave that answers in the last allowed cycle beats the timeout.
  assign in_access = (state == ACCESS);
  assign timeout   = in_access & ~decode_err & (cnt == CNT_LAST) & ~slv_ready;
  assign rsp_ready = in_access & (decode_err | slv_ready | timeout);
  assign rsp_error = rsp_ready & (decode_err | timeout | slv_error);

  assign bus.o_arbiter_READY = rsp_ready;
  assign bus.o_arbiter_ERROR = rsp_error;
  assign bus.o_arbiter_DATA  = (rsp_ready & ~rsp_error) ? slv_data : '0;
  assign bus.o_arbiter_SEL   = idx;
  assign bus.o_busy          = (state != IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      idx        <= '0;
      decode_err <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m_psel && !bus.m_penable) begin
            state      <= SETUP;
            idx        <= sel_idx;
            decode_err <= sel_bad;
          end
        end
        SETUP: begin
          if (!bus.m_psel) begin
            state <= IDLE;
          end else if (bus.m_penable) begin
            state <= ACCESS;
            cnt   <= '0;
          end else begin
            idx        <= sel_idx;
            decode_err <= sel_bad;
          end
        end
        ACCESS: begin
          if (rsp_ready) begin
            cnt <= '0;
            if (bus.m_psel && !bus.m_penable) begin
              state      <= SETUP;
              idx        <= sel_idx;
              decode_err <= sel_bad;
            end else begin
              state <= IDLE;
            end
          end else if (!bus.m_psel) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef APB_RESP_MUX_STATS_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      o_err_cnt     <= '0;
      o_timeout_cnt <= '0;
    end else begin
      if (rsp_error && (o_err_cnt != 16'hFFFF)) o_err_cnt <= o_err_cnt + 16'd1;
      if (timeout && (o_timeout_cnt != 16'hFFFF)) o_timeout_cnt <= o_timeout_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_apb_resp_mux.sv
// tb/tb_apb_resp_mux.sv - randomized transfer-level checking of apb_resp_mux against a behavioural model
module tb_apb_resp_mux;
  localparam int NS = 3;
  localparam int DW = 32;
  localparam int TO = 4;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_resp_mux_if #(.NUM_SLAVES(NS), .DATA_WIDTH(DW)) bus ();

`ifdef APB_RESP_MUX_STATS_EN
  logic [15:0] o_err_cnt;
  logic [15:0] o_timeout_cnt;
`endif

  apb_resp_mux #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
`ifdef APB_RESP_MUX_STATS_EN
    .o_err_cnt     (o_err_cnt),
    .o_timeout_cnt (o_timeout_cnt),
`endif
    .bus           (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit          chk_en = 1'b0;
  bit          exp_busy, exp_ready, exp_error, exp_sel_known;
  logic [31:0] exp_data;
  logic [1:0]  exp_sel;
  int          exp_err_cnt = 0, exp_to_cnt = 0;
  bit          pend_err = 1'b0, pend_to = 1'b0;
  int          acc_n;
  logic [31:0] obs_data;
  bit          obs_err;
  logic [1:0]  obs_sel;
  int          obs_n;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit onehot(input logic [2:0] s);
    return (s != 3'b000) && ((s & (s - 3'b001)) == 3'b000);
  endfunction

  function automatic int idx_of(input logic [2:0] s);
    for (int i = 0; i < NS; i++) if (s[i]) return i;
    return 0;
  endfunction

  function automatic logic [2:0] pick_sel();
    if ($urandom_range(0, 7) == 0) return 3'($urandom);
    return 3'b001 << $urandom_range(0, 2);
  endfunction

  always @(negedge PCLK) begin
    if (chk_en) begin
      chk("busy",  bus.o_busy,          exp_busy);
      chk("ready", bus.o_arbiter_READY, exp_ready);
      chk("error", bus.o_arbiter_ERROR, exp_error);
      chk("data",  bus.o_arbiter_DATA,  exp_data);
      if (exp_sel_known) chk("sel", bus.o_arbiter_SEL, exp_sel);
`ifdef APB_RESP_MUX_STATS_EN
      chk("err_cnt",     o_err_cnt,     exp_err_cnt);
      chk("timeout_cnt", o_timeout_cnt, exp_to_cnt);
`endif
      if (exp_ready) begin
        obs_data = bus.o_arbiter_DATA;
        obs_err  = bus.o_arbiter_ERROR;
        obs_sel  = bus.o_arbiter_SEL;
        obs_n    = acc_n;
      end
    end
  end

  task automatic set_exp(input bit b, input bit r, input bit e, input logic [31:0] d);
    exp_busy = b; exp_ready = r; exp_error = e; exp_data = d;
  endtask

  // One clock: counters bump the cycle after a completion, then new inputs with noise on every slave.
  task automatic step(input logic psel, input logic pen, input logic [2:0] s);
    @(posedge PCLK); #1;
    if (pend_err && exp_err_cnt < 16'hFFFF) exp_err_cnt++;
    if (pend_to && exp_to_cnt < 16'hFFFF) exp_to_cnt++;
    pend_err = 1'b0; pend_to = 1'b0;
    bus.m_psel = psel; bus.m_penable = pen; bus.sel = s;
    bus.s_ready = 3'($urandom); bus.s_error = 3'($urandom);
    bus.s_data  = {$urandom, $urandom, $urandom};
  endtask

  task automatic idle_cycle();
    bit viol;
    viol = ($urandom_range(0, 3) == 0);
    step(viol, viol, 3'($urandom));
    set_exp(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Slave answers in ACCESS cycle w (large w = never); completion is at min(w, TO-1), or first cycle on a bad select.
  task automatic xfer(input logic [2:0] s, input int w, input bit serr, input logic [31:0] d,
                      input bit merged, input bit extra_setup, input int abort_at,
                      input bit b2b, input logic [2:0] nsel, output bit went_b2b);
    bit dec, fin, ab;
    int i, done;
    logic [2:0] dummy;
    dec = !onehot(s);
    i = idx_of(s);
    done = dec ? 0 : ((w < TO - 1) ? w : TO - 1);
    went_b2b = 1'b0;
    if (!merged) begin
      dummy = extra_setup ? (3'b001 << $urandom_range(0, 2)) : s;
      step(1'b1, 1'b0, dummy);
      set_exp(1'b0, 1'b0, 1'b0, 32'h0);
      if (extra_setup) begin
        step(1'b1, 1'b0, s);
        set_exp(1'b1, 1'b0, 1'b0, 32'h0);
        exp_sel = 2'(idx_of(dummy)); exp_sel_known = 1'b1;
      end
    end
    step(1'b1, 1'b1, s);
    set_exp(1'b1, 1'b0, 1'b0, 32'h0);
    exp_sel = 2'(i); exp_sel_known = !dec;
    for (int n = 0; n < TO + 8; n++) begin
      fin = (n == done);
      ab  = (abort_at >= 0) && (n == abort_at) && (n < done);
      step(!ab, !(fin && b2b), (fin && b2b) ? nsel : 3'($urandom));
      if (!dec) begin
        bus.s_ready[i] = (n == w);
        if (n == w) begin
          bus.s_error[i] = serr;
          bus.s_data[i*DW +: DW] = d;
        end
      end
      exp_busy  = 1'b1;
      exp_ready = fin;
      exp_error = fin && (dec || (n != w) || serr);
      exp_data  = (fin && !dec && (n == w) && !serr) ? d : 32'h0;
      acc_n = n;
      if (fin && exp_error) pend_err = 1'b1;
      if (fin && !dec && (n != w)) pend_to = 1'b1;
      if (fin) begin
        went_b2b = b2b;
        break;
      end
      if (ab) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          b2b_flag, b2b, es;
    logic [2:0]  s_cur, s_nxt;
    int          ab;

    bus.m_psel = 1'b0; bus.m_penable = 1'b0; bus.sel = '0;
    bus.s_ready = '0; bus.s_error = '0; bus.s_data = '0;
    #3;
    chk("reset_busy",  bus.o_busy,          1'b0);
    chk("reset_ready", bus.o_arbiter_READY, 1'b0);
    chk("reset_error", bus.o_arbiter_ERROR, 1'b0);
    chk("reset_data",  bus.o_arbiter_DATA,  32'h0);
    chk("reset_sel",   bus.o_arbiter_SEL,   2'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0, 32'h0); exp_sel = 2'd0; exp_sel_known = 1'b1;
    chk_en = 1'b1;

    xfer(3'b010, 0, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0, -1, 1'b0, 3'b000, b2b_flag);
    idle_cycle();
    chk("t1_data", obs_data, 32'hA5A5_0001);
    chk("t1_err",  obs_err,  1'b0);
    chk("t1_sel",  obs_sel,  2'd1);
    chk("t1_lat",  obs_n,    0);

    xfer(3'b100, 2, 1'b1, 32'h1234_5678, 1'b0, 1'b0, -1, 1'b0, 3'b000, b2b_flag);
    idle_cycle();
    chk("t2_lat",  obs_n,    2);
    chk("t2_err",  obs_err,  1'b1);
    chk("t2_data", obs_data, 32'h0);
    chk("t2_sel",  obs_sel,  2'd2);

    xfer(3'b011, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, -1, 1'b0, 3'b000, b2b_flag);
    idle_cycle();
    chk("t3_lat",  obs_n,    0);
    chk("t3_err",  obs_err,  1'b1);
    chk("t3_data", obs_data, 32'h0);
`ifdef APB_RESP_MUX_STATS_EN
    chk("t3_err_cnt", o_err_cnt, 16'd2);
`endif

    xfer(3'b001, 100, 1'b0, 32'h0, 1'b0, 1'b0, -1, 1'b0, 3'b000, b2b_flag);
    idle_cycle();
    chk("t4_lat", obs_n,   3);
    chk("t4_err", obs_err, 1'b1);
`ifdef APB_RESP_MUX_STATS_EN
    chk("t4_timeout_cnt", o_timeout_cnt, 16'd1);
    chk("t4_err_cnt",     o_err_cnt,     16'd3);
`endif

    xfer(3'b001, 1, 1'b0, 32'h0000_5A01, 1'b0, 1'b0, -1, 1'b1, 3'b100, b2b_flag);
    chk("t5_b2b", b2b_flag, 1'b1);
    xfer(3'b100, 0, 1'b0, 32'hB2B0_0002, 1'b1, 1'b0, -1, 1'b0, 3'b000, b2b_flag);
    idle_cycle();
    chk("t5_data", obs_data, 32'hB2B0_0002);
    chk("t5_sel",  obs_sel,  2'd2);

    // Reset while slave 2 is holding off an ACCESS.
    step(1'b1, 1'b0, 3'b100);
    set_exp(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 3'b100);
    set_exp(1'b1, 1'b0, 1'b0, 32'h0); exp_sel = 2'd2; exp_sel_known = 1'b1;
    step(1'b1, 1'b1, 3'b100);
    bus.s_ready[2] = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge PCLK); #1;
    chk_en = 1'b0;
    #2;
    PRESETn = 1'b0;
    #1;
    chk("arst_busy",  bus.o_busy,          1'b0);
    chk("arst_ready", bus.o_arbiter_READY, 1'b0);
    chk("arst_error", bus.o_arbiter_ERROR, 1'b0);
    chk("arst_data",  bus.o_arbiter_DATA,  32'h0);
    chk("arst_sel",   bus.o_arbiter_SEL,   2'd0);
`ifdef APB_RESP_MUX_STATS_EN
    chk("arst_err_cnt", o_err_cnt, 16'd0);
`endif
    bus.m_psel = 1'b0; bus.m_penable = 1'b0;
    exp_err_cnt = 0; exp_to_cnt = 0; pend_err = 1'b0; pend_to = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0, 32'h0); exp_sel = 2'd0; exp_sel_known = 1'b1;
    chk_en = 1'b1;

    xfer(3'b010, 1, 1'b0, 32'hC0DE_0003, 1'b0, 1'b0, -1, 1'b0, 3'b000, b2b_flag);
    idle_cycle();
    chk("t6_data", obs_data, 32'hC0DE_0003);
    chk("t6_lat",  obs_n,    1);

    b2b_flag = 1'b0;
    s_cur = pick_sel();
    for (int t = 0; t < 200; t++) begin
      s_nxt = pick_sel();
      b2b   = (t != 199) && ($urandom_range(0, 2) == 0);
      ab    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
      es    = !b2b_flag && ($urandom_range(0, 3) == 0);
      xfer(s_cur, int'($urandom_range(0, 6)), 1'($urandom), $urandom,
           b2b_flag, es, ab, b2b, s_nxt, b2b_flag);
      if (!b2b_flag) repeat ($urandom_range(0, 2)) idle_cycle();
      s_cur = s_nxt;
    end
    idle_cycle();
    idle_cycle();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
